// File: rtl/sha256_mem_arbiter.sv
// sha256_mem_arbiter: round-robin, burst-locked sharing of one memory read port
// among N_REQ chunk fetchers, with an in-order tag FIFO routing returns back.
module sha256_mem_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DEPTH     = 8,
    parameter int BURST_LEN = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_addr_vld,
    input  logic [N_REQ-1:0][31:0]      req_addr,
    output logic [N_REQ-1:0]            req_gnt,
    output logic [N_REQ-1:0]            req_data_vld,
    output logic [31:0]                 req_data,
    output logic                        mem_addr_vld,
    output logic [31:0]                 mem_addr,
    input  logic                        mem_data_vld,
    input  logic [31:0]                 mem_data,
    output logic [$clog2(DEPTH):0]      outstanding,
    output logic                        err_orphan
);
    localparam int IW = $clog2(N_REQ);
    localparam int PW = $clog2(DEPTH);
    localparam int OW = PW + 1;
    localparam int CW = $clog2(BURST_LEN + 1);

    logic [IW-1:0]    rr_ptr_q, rr_ptr_d, owner_q, owner_d, rr_win, win;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             prev_q, prev_d, found, lock, push, pop;
    logic [IW-1:0]    tag_q [DEPTH];
    logic [IW-1:0]    tag_d [DEPTH];
    logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [OW-1:0]    occ_q, occ_d;
    logic [N_REQ-1:0] dvld_q, dvld_d;
    logic [31:0]      data_q, data_d, maddr_q, maddr_d;
    logic             mvld_q, mvld_d, orphan_q, orphan_d;

    function automatic logic [IW-1:0] wrap(input int v);
        return IW'(v % N_REQ);
    endfunction

    always_comb begin
        rr_win = rr_ptr_q;
        found  = 1'b0;
        for (int i = 0; i < N_REQ; i++)
            if (!found && req_addr_vld[wrap(int'(rr_ptr_q) + i)]) begin
                found  = 1'b1;
                rr_win = wrap(int'(rr_ptr_q) + i);
            end
        // prev_q means the lock owner was granted last cycle
        lock     = prev_q && req_addr_vld[owner_q] && cnt_q < CW'(BURST_LEN);
        win      = lock ? owner_q : rr_win;
        push     = !rst && found && occ_q < OW'(DEPTH);
        pop      = mem_data_vld && occ_q != '0;
        req_gnt  = push ? N_REQ'(1) << win : '0;
        cnt_d    = push ? (lock ? cnt_q + CW'(1) : CW'(1)) : cnt_q;
        owner_d  = push ? win : owner_q;
        prev_d   = push;
        rr_ptr_d = rr_ptr_q;
        if (prev_q && (!push || !req_addr_vld[owner_q]))
            rr_ptr_d = wrap(int'(owner_q) + 1);
        if (push && cnt_d == CW'(BURST_LEN))
            rr_ptr_d = wrap(int'(win) + 1);
        tag_d = tag_q;
        if (push)
            tag_d[wr_q] = win;
        wr_d     = wr_q + PW'(push);
        rd_d     = rd_q + PW'(pop);
        occ_d    = occ_q + OW'(push) - OW'(pop);
        dvld_d   = pop ? N_REQ'(1) << tag_q[rd_q] : '0;
        data_d   = pop ? mem_data : data_q;
        mvld_d   = push;
        maddr_d  = push ? req_addr[win] : maddr_q;
        orphan_d = orphan_q || (mem_data_vld && occ_q == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= '0;
            owner_q  <= '0;
            cnt_q    <= '0;
            prev_q   <= 1'b0;
            tag_q    <= '{default: '0};
            wr_q     <= '0;
            rd_q     <= '0;
            occ_q    <= '0;
            dvld_q   <= '0;
            data_q   <= '0;
            mvld_q   <= 1'b0;
            maddr_q  <= '0;
            orphan_q <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            cnt_q    <= cnt_d;
            prev_q   <= prev_d;
            tag_q    <= tag_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            occ_q    <= occ_d;
            dvld_q   <= dvld_d;
            data_q   <= data_d;
            mvld_q   <= mvld_d;
            maddr_q  <= maddr_d;
            orphan_q <= orphan_d;
        end
    end

    assign req_data_vld = dvld_q;
    assign req_data     = data_q;
    assign mem_addr_vld = mvld_q;
    assign mem_addr     = maddr_q;
    assign outstanding  = occ_q;
    assign err_orphan   = orphan_q;
endmodule
